// File: rtl/r_rd_arbiter.sv
// Round-robin arbiter merging NUM_SRC AXI R-channel sources, with bursts held locked until last.
// Optional stall watchdog built only when R_ARB_WDOG_EN is defined.
module r_rd_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int ID_WIDTH    = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int RESP_WIDTH  = 2,
    parameter int WDOG_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_SRC-1:0]               s_valid,
    input  logic [NUM_SRC*ID_WIDTH-1:0]      s_id,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    s_data,
    input  logic [NUM_SRC*RESP_WIDTH-1:0]    s_resp,
    input  logic [NUM_SRC-1:0]               s_last,
    output logic [NUM_SRC-1:0]               s_ready,
    output logic                             m_valid,
    output logic [ID_WIDTH-1:0]              m_id,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [RESP_WIDTH-1:0]            m_resp,
    output logic                             m_last,
    input  logic                             m_ready,
    output logic [2:0]                       grant_idx,
    output logic                             stall_err
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t     state_q, state_d;
    logic [2:0] rr_ptr_q, rr_ptr_d;
    logic [2:0] lock_idx_q, lock_idx_d;
    logic [2:0] sel, sel_hi, sel_lo;
    logic       found, found_hi, found_lo;
    logic       hs;

    function automatic logic [2:0] next_idx(input logic [2:0] x);
        if (int'(x) == NUM_SRC - 1) return 3'd0;
        return x + 3'd1;
    endfunction

    // Two-pass search: first requester at or above rr_ptr, else first requester below it.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = 3'd0;
        sel_lo   = 3'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found_hi && s_valid[i] && (i >= int'(rr_ptr_q))) begin
                found_hi = 1'b1;
                sel_hi   = 3'(i);
            end
            if (!found_lo && s_valid[i]) begin
                found_lo = 1'b1;
                sel_lo   = 3'(i);
            end
        end
        if (state_q == LOCKED) begin
            found = 1'b1;
            sel   = lock_idx_q;
        end else if (found_hi) begin
            found = 1'b1;
            sel   = sel_hi;
        end else if (found_lo) begin
            found = 1'b1;
            sel   = sel_lo;
        end else begin
            found = 1'b0;
            sel   = rr_ptr_q;
        end
    end

    assign grant_idx = sel;

    // Output mux; rst_n gates the handshake signals so reset takes effect without a clock.
    always_comb begin
        m_valid = 1'b0;
        m_id    = '0;
        m_data  = '0;
        m_resp  = '0;
        m_last  = 1'b0;
        s_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (found && (3'(i) == sel)) begin
                m_valid    = s_valid[i] & rst_n;
                m_id       = s_id[i*ID_WIDTH +: ID_WIDTH];
                m_data     = s_data[i*DATA_WIDTH +: DATA_WIDTH];
                m_resp     = s_resp[i*RESP_WIDTH +: RESP_WIDTH];
                m_last     = s_last[i];
                s_ready[i] = m_ready & rst_n;
            end
        end
    end

    assign hs = m_valid & m_ready;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            IDLE: begin
                if (hs && m_last) begin
                    rr_ptr_d = next_idx(sel);
                end else if (m_valid) begin
                    state_d    = LOCKED;
                    lock_idx_d = sel;
                end
            end
            LOCKED: begin
                if (hs && m_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_idx(lock_idx_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 3'd0;
            lock_idx_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

`ifdef R_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              stall_err_q, stall_err_d;

    // Saturating count of back-to-back stalled cycles while a burst holds the channel.
    always_comb begin
        wdog_cnt_d  = wdog_cnt_q;
        stall_err_d = stall_err_q;
        if ((state_q != LOCKED) || hs) begin
            wdog_cnt_d = '0;
        end else if (wdog_cnt_q != WDOG_W'(WDOG_CYCLES)) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
        if (wdog_cnt_d == WDOG_W'(WDOG_CYCLES)) stall_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q  <= '0;
            stall_err_q <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign stall_err = stall_err_q;
`else
    assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_r_rd_arbiter.sv
// Scoreboard bench for r_rd_arbiter: per-source beat queues feed the DUT, expected grant order is queued up front.
module tb_r_rd_arbiter;

    localparam int NUM_SRC     = 4;
    localparam int ID_WIDTH    = 4;
    localparam int DATA_WIDTH  = 64;
    localparam int RESP_WIDTH  = 2;
    localparam int WDOG_CYCLES = 8;
`ifdef R_ARB_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [RESP_WIDTH-1:0] resp;
        logic                  last;
    } beat_t;

    typedef struct packed {
        logic [2:0] src;
        beat_t      beat;
    } exp_t;

    logic                          clk;
    logic                          rst_n;
    logic [NUM_SRC-1:0]            s_valid;
    logic [NUM_SRC*ID_WIDTH-1:0]   s_id;
    logic [NUM_SRC*DATA_WIDTH-1:0] s_data;
    logic [NUM_SRC*RESP_WIDTH-1:0] s_resp;
    logic [NUM_SRC-1:0]            s_last;
    logic [NUM_SRC-1:0]            s_ready;
    logic                          m_valid;
    logic [ID_WIDTH-1:0]           m_id;
    logic [DATA_WIDTH-1:0]         m_data;
    logic [RESP_WIDTH-1:0]         m_resp;
    logic                          m_last;
    logic                          m_ready;
    logic [2:0]                    grant_idx;
    logic                          stall_err;

    beat_t              src_q [NUM_SRC][$];
    exp_t               exp_q [$];
    logic [NUM_SRC-1:0] hold;
    logic [NUM_SRC-1:0] hs_cap;
    logic               mr;
    int                 seq;
    int                 checks;
    int                 errors;

    r_rd_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RESP_WIDTH (RESP_WIDTH),
        .WDOG_CYCLES(WDOG_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_id     (s_id),
        .s_data   (s_data),
        .s_resp   (s_resp),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .m_valid  (m_valid),
        .m_id     (m_id),
        .m_data   (m_data),
        .m_resp   (m_resp),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .grant_idx(grant_idx),
        .stall_err(stall_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic beat_t mk(input int src, input int n, input bit last);
        beat_t b;
        b.id   = ID_WIDTH'(src + 3);
        b.data = 64'hC0DE_0000_0000_0000 | DATA_WIDTH'(src * 4096 + n);
        b.resp = RESP_WIDTH'(n);
        b.last = last;
        return b;
    endfunction

    task automatic push_src(input int src, input beat_t b);
        src_q[src].push_back(b);
    endtask

    task automatic push_exp(input int src, input beat_t b);
        exp_t e;
        e.src  = 3'(src);
        e.beat = b;
        exp_q.push_back(e);
    endtask

    // Send one beat from src and predict it as the next beat out of the channel.
    task automatic send(input int src, input bit last);
        beat_t b;
        seq++;
        b = mk(src, seq, last);
        push_src(src, b);
        push_exp(src, b);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() > 0) begin
                s_valid[i]                          = ~hold[i];
                s_id[i*ID_WIDTH +: ID_WIDTH]         = src_q[i][0].id;
                s_data[i*DATA_WIDTH +: DATA_WIDTH]   = src_q[i][0].data;
                s_resp[i*RESP_WIDTH +: RESP_WIDTH]   = src_q[i][0].resp;
                s_last[i]                           = src_q[i][0].last;
            end else begin
                s_valid[i]                          = 1'b0;
                s_id[i*ID_WIDTH +: ID_WIDTH]         = '0;
                s_data[i*DATA_WIDTH +: DATA_WIDTH]   = '0;
                s_resp[i*RESP_WIDTH +: RESP_WIDTH]   = '0;
                s_last[i]                           = 1'b0;
            end
        end
    endtask

    // One clock: retire accepted beats, drive the new inputs, then sample and score at negedge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_SRC; i++)
            if (hs_cap[i] && (src_q[i].size() > 0)) void'(src_q[i].pop_front());
        m_ready = mr;
        drive_inputs();
        @(negedge clk);
        hs_cap = s_valid & s_ready;
        if (m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got grant=%0d data=%h, want no beat", grant_idx, m_data);
            end else begin
                e = exp_q.pop_front();
                if (grant_idx !== e.src || m_data !== e.beat.data || m_id !== e.beat.id ||
                    m_resp !== e.beat.resp || m_last !== e.beat.last) begin
                    errors++;
                    $display("FAIL beat_order: got grant=%0d id=%h data=%h resp=%0d last=%b, want grant=%0d id=%h data=%h resp=%0d last=%b",
                             grant_idx, m_id, m_data, m_resp, m_last,
                             e.src, e.beat.id, e.beat.data, e.beat.resp, e.beat.last);
                end
            end
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d beats outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic flush_sources();
        for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
        exp_q.delete();
        hs_cap = '0;
        hold   = '0;
        drive_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) push_src(i, mk(i, 0, 1'b1));
        drive_inputs();
        #1;
        checks++;
        if (s_ready !== 4'b0000 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got s_ready=%b m_valid=%b, want 0000 0", s_ready, m_valid);
        end
        checks++;
        if (grant_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_grant: got %0d, want 0", grant_idx);
        end
        checks++;
        if (stall_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall_err: got %b, want 0", stall_err);
        end
        flush_sources();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        mr = 1'b1;
        send(0, 1'b1);
        send(1, 1'b1);
        send(2, 1'b1);
        send(3, 1'b1);
        send(0, 1'b1);
        for (int c = 0; c < 5; c++) tick();
        check_drained("round_robin");
    endtask

    task automatic test_burst_lock();
        beat_t b0, b2;
        seq++; b0 = mk(0, seq, 1'b1); push_src(0, b0);
        seq++; b2 = mk(2, seq, 1'b1); push_src(2, b2);
        send(1, 1'b0);
        send(1, 1'b0);
        send(1, 1'b0);
        send(1, 1'b1);
        push_exp(2, b2);
        push_exp(0, b0);
        for (int c = 0; c < 6; c++) tick();
        check_drained("burst_lock");
    endtask

    task automatic test_backpressure();
        beat_t a5, b0;
        mr = 1'b0;
        a5 = '{id: 4'h3, data: 64'hA5, resp: 2'd0, last: 1'b1};
        push_src(3, a5);
        push_exp(3, a5);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 0) begin
                seq++; b0 = mk(0, seq, 1'b1); push_src(0, b0); push_exp(0, b0);
            end
            checks++;
            if (m_data !== 64'hA5 || grant_idx !== 3'd3 || m_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d: got data=%h grant=%0d valid=%b, want data=a5 grant=3 valid=1",
                         c, m_data, grant_idx, m_valid);
            end
        end
        mr = 1'b1;
        tick();
        tick();
        check_drained("backpressure");
    endtask

    task automatic test_bubble();
        beat_t b0;
        send(2, 1'b0);
        send(2, 1'b0);
        send(2, 1'b1);
        seq++; b0 = mk(0, seq, 1'b1); push_src(0, b0); push_exp(0, b0);
        tick();
        hold[2] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (m_valid !== 1'b0 || grant_idx !== 3'd2 || s_ready !== 4'b0100) begin
                errors++;
                $display("FAIL bubble_hold cycle %0d: got valid=%b grant=%0d s_ready=%b, want 0 2 0100",
                         c, m_valid, grant_idx, s_ready);
            end
        end
        hold[2] = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        check_drained("bubble");
    endtask

    task automatic test_reset_mid_burst();
        send(1, 1'b0);
        send(1, 1'b0);
        send(1, 1'b0);
        send(1, 1'b1);
        tick();
        mr = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_ready !== 4'b0000 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_burst_outputs: got s_ready=%b m_valid=%b, want 0000 0", s_ready, m_valid);
        end
        flush_sources();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mr = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) send(i, 1'b1);
        for (int c = 0; c < 4; c++) tick();
        check_drained("reset_mid_burst");
    endtask

    task automatic test_watchdog();
        send(0, 1'b0);
        send(0, 1'b1);
        tick();
        hold[0] = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        checks++;
        if (stall_err !== 1'b0) begin
            errors++;
            $display("FAIL wdog_early: got stall_err=%b, want 0", stall_err);
        end
        tick();
        checks++;
        if (stall_err !== WDOG_ON) begin
            errors++;
            $display("FAIL wdog_trip: got stall_err=%b, want %b", stall_err, WDOG_ON);
        end
        hold[0] = 1'b0;
        tick();
        tick();
        checks++;
        if (stall_err !== WDOG_ON) begin
            errors++;
            $display("FAIL wdog_sticky: got stall_err=%b, want %b", stall_err, WDOG_ON);
        end
        check_drained("watchdog");
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        seq     = 0;
        hold    = '0;
        hs_cap  = '0;
        mr      = 1'b1;
        m_ready = 1'b1;
        rst_n   = 1'b0;
        s_valid = '0;
        s_id    = '0;
        s_data  = '0;
        s_resp  = '0;
        s_last  = '0;
        #12;
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_backpressure();
        test_bubble();
        test_reset_mid_burst();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
